mult_input_conditioner: RTL
===========================

// Module: mult_input_conditioner
// PURPOSE
// Upstream front end of the 8-bit shift-add multiplier. Converts the raw, bouncy,
// asynchronous board inputs into clean synchronous controls: two active-low push
// buttons and eight slide switches. It produces a one-cycle ClearA_LoadB pulse, a
// debounced Execute level, and an operand bus Din that stays frozen while a multiply
// runs, so the multiplier sees a stable addend on every add/subtract cycle.
// PARAMETERS
// DEBOUNCE_CYCLES  500000  consecutive stable synchronized samples needed to accept a level change (>=2)
// EXEC_HOLD        4       Execute pulse length in cycles when EXEC_PULSE_EN is defined (>=1)
// PORTS
// Clk             in   1  system clock
// Reset           in   1  asynchronous, active-high reset
// ClearA_LoadB_n  in   1  raw push button, active low, asynchronous
// Run_n           in   1  raw push button, active low, asynchronous
// SW              in   8  raw slide switches, asynchronous
// ClearA_LoadB    out  1  one-cycle pulse per accepted press
// Execute         out  1  debounced run request to the multiplier FSM
// Din             out  8  operand to the multiplier (B load value and addend)
// BEHAVIOUR
// - Reset (async, high): all sync flops, counters and FSMs clear to the released/idle state;
//   ClearA_LoadB=0, Execute=0, Din=8'h00. Both buttons are treated as released after reset.
// - Synchronization: each button and SW bit passes through two flops. The button is
//   inverted after synchronization, so pressed=1. Raw input to usable sample takes 2 cycles.
// - Per-button debounce FSM (identical instance for each button), count width = $clog2(DEBOUNCE_CYCLES+1):
//   REL   : sample=1 -> CHK_P, count=1; otherwise stay.
//   CHK_P : sample=1 -> count++; when count==DEBOUNCE_CYCLES -> PRS. sample=0 -> REL.
//   PRS   : sample=0 -> CHK_R, count=1; otherwise stay.
//   CHK_R : sample=0 -> count++; when count==DEBOUNCE_CYCLES -> REL. sample=1 -> PRS.
//   Debounced level = 1 in PRS and CHK_R, 0 in REL and CHK_P.
//   Any glitch shorter than DEBOUNCE_CYCLES produces no level change.
// - ClearA_LoadB: registered. High for exactly 1 cycle, on the cycle after the ClearA_LoadB
//   button's FSM enters PRS. Holding the button produces no further pulses.
// - Execute (default build): registered copy of the Run button's debounced level. It stays
//   high while the button is held, which lets the multiplier reach its hold state and wait
//   for release.
// - Din: registered.
//   - While Execute=0: Din = synchronized SW, so Din follows the switches with 3 cycles of latency.
//   - On the cycle Execute rises, Din captures the current synchronized SW.
//   - While Execute=1: Din holds that captured value, and switch changes are ignored.
//   - When Execute falls, tracking resumes on the next cycle.
// - Simultaneous presses: the two FSMs are independent. ClearA_LoadB is never suppressed,
//   because it is the abort path. If it fires while Execute=1, Din stays frozen and that
//   frozen value is what gets loaded into B.
// - Reset mid-debounce or mid-Execute: all outputs drop in the same cycle (async).
//   A button still held when Reset releases has to go through the full CHK_P qualification
//   again before it is accepted.
// CONFIGURATION
// - EXEC_PULSE_EN defined:
//   - Execute is a fixed pulse of exactly EXEC_HOLD cycles, starting 1 cycle after the Run FSM enters PRS.
//   - A new pulse can start only after the Run FSM has returned to REL.
//   - The Din freeze window equals the pulse window.
//   - One press gives one multiply, whatever the hold time.
// - EXEC_PULSE_EN undefined: Execute follows the debounced level, as described above.
// TESTING (DEBOUNCE_CYCLES=4, EXEC_HOLD=4 for simulation)
// 1. Reset high with buttons held low -> all outputs 0. Release Reset with Run_n held low
//    -> Execute rises 4+2+1 = 7 cycles later.
// 2. ClearA_LoadB_n pulsed low 1,2,3 cycles with gaps -> no ClearA_LoadB.
//    Held low 10 cycles -> exactly one 1-cycle pulse.
// 3. SW=8'h5A, press Run; while Execute=1 set SW=8'hFF -> Din stays 8'h5A.
//    Release Run -> Din=8'hFF within 3 cycles after Execute falls.
// 4. Run_n bounces 1010 then stays low; release with bounce 0101 then stays high
//    -> a single clean Execute high interval, no extra edges.
// 5. Both buttons pressed in the same cycle -> ClearA_LoadB pulse and Execute rise in the same cycle.
//    Din at that time = SW captured at that cycle.
// 6. EXEC_PULSE_EN defined, Run held for 50 cycles -> Execute high exactly 4 cycles and one pulse only.
//    Release, press again -> second 4-cycle pulse.

Source files
------------

// File: rtl/mult_input_conditioner.sv
// mult_input_conditioner: board push-button and switch front end for the 8-bit shift-add multiplier.
// Build option EXEC_PULSE_EN: Execute becomes a fixed EXEC_HOLD-cycle pulse per accepted Run press.

// Per-button debouncer: four-state qualify/hold FSM on an already-synchronized, active-high sample.
// Latency: level changes on the edge that sees the DEBOUNCE_CYCLES-th consecutive differing sample.
// Backpressure: none; evaluates every Clk.
module mult_input_conditioner_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic Clk,
    input  logic Reset,
    input  logic sample,
    output logic level
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    // The sample that would take count to DEBOUNCE_CYCLES is the one that qualifies the change.
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        REL,
        CHK_P,
        PRS,
        CHK_R
    } db_state_t;

    db_state_t     state;
    db_state_t     state_nxt;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= REL;
            count <= '0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        unique case (state)
            REL: begin
                if (sample) begin
                    state_nxt = CHK_P;
                    count_nxt = CW'(1);
                end
            end
            CHK_P: begin
                if (!sample) begin
                    state_nxt = REL;
                end else if (count == LAST) begin
                    state_nxt = PRS;
                end else begin
                    count_nxt = count + 1'b1;
                end
            end
            PRS: begin
                if (!sample) begin
                    state_nxt = CHK_R;
                    count_nxt = CW'(1);
                end
            end
            CHK_R: begin
                if (sample) begin
                    state_nxt = PRS;
                end else if (count == LAST) begin
                    state_nxt = REL;
                end else begin
                    count_nxt = count + 1'b1;
                end
            end
            default: begin
                state_nxt = REL;
                count_nxt = '0;
            end
        endcase
    end

    assign level = (state == PRS) || (state == CHK_R);
endmodule

// Two-flop synchronizers, two debouncers, ClearA_LoadB pulse, Execute and frozen-operand Din.
// Latency: raw to sample 2 cycles; SW to Din 3 cycles; Execute/ClearA_LoadB 1 cycle after PRS entry.
// Backpressure: none; outputs are free-running registers.
module mult_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int EXEC_HOLD       = 4
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       ClearA_LoadB_n,
    input  logic       Run_n,
    input  logic [7:0] SW,
    output logic       ClearA_LoadB,
    output logic       Execute,
    output logic [7:0] Din
);
    if (DEBOUNCE_CYCLES < 2 || EXEC_HOLD < 1) begin : g_param_check
        $error("mult_input_conditioner: DEBOUNCE_CYCLES must be >= 2 and EXEC_HOLD >= 1");
    end

    logic [1:0] clr_sync;
    logic [1:0] run_sync;
    logic [7:0] sw_meta;
    logic [7:0] sw_sync;
    logic       clr_level;
    logic       run_level;
    logic       clr_level_q;

    // Button synchronizers reset high so both buttons read as released.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            clr_sync <= 2'b11;
            run_sync <= 2'b11;
            sw_meta  <= 8'h00;
            sw_sync  <= 8'h00;
        end else begin
            clr_sync <= {clr_sync[0], ClearA_LoadB_n};
            run_sync <= {run_sync[0], Run_n};
            sw_meta  <= SW;
            sw_sync  <= sw_meta;
        end
    end

    mult_input_conditioner_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_clr_db (
        .Clk   (Clk),
        .Reset (Reset),
        .sample(~clr_sync[1]),
        .level (clr_level)
    );

    mult_input_conditioner_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_run_db (
        .Clk   (Clk),
        .Reset (Reset),
        .sample(~run_sync[1]),
        .level (run_level)
    );

    // A rising debounced level only happens on CHK_P -> PRS, so this is one pulse per accepted press.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            clr_level_q  <= 1'b0;
            ClearA_LoadB <= 1'b0;
        end else begin
            clr_level_q  <= clr_level;
            ClearA_LoadB <= clr_level & ~clr_level_q;
        end
    end

`ifdef EXEC_PULSE_EN
    localparam int HW = (EXEC_HOLD > 1) ? $clog2(EXEC_HOLD) : 1;

    logic [HW-1:0] hold_cnt;
    logic          run_level_q;

    // Run level can only rise again after the FSM has passed back through REL, so each press
    // arms exactly one pulse regardless of how long the button is held.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            run_level_q <= 1'b0;
            Execute     <= 1'b0;
            hold_cnt    <= '0;
        end else begin
            run_level_q <= run_level;
            if (!Execute && run_level && !run_level_q) begin
                Execute  <= 1'b1;
                hold_cnt <= HW'(EXEC_HOLD - 1);
            end else if (Execute) begin
                if (hold_cnt == '0) begin
                    Execute <= 1'b0;
                end else begin
                    hold_cnt <= hold_cnt - 1'b1;
                end
            end
        end
    end
`else
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            Execute <= 1'b0;
        end else begin
            Execute <= run_level;
        end
    end
`endif

    // The capture happens on the edge Execute rises (Execute still 0 there); the hold starts after.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            Din <= 8'h00;
        end else if (!Execute) begin
            Din <= sw_sync;
        end
    end
endmodule
